// File: rtl/hazard_pkg.sv
// Shared types, forwarding encodings and scoreboard compare helpers
// for the 5-stage pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // XZR is hard-wired zero, so a write to it never produces a dependency.
  function automatic logic sb_match(input sb_entry_t e, input logic [4:0] r);
    return e.valid && e.regwrite && (e.rd == r) && (r != XZR);
  endfunction

  // Returns {load_use, fwd_sel}; the youngest producer wins.
  function automatic logic [2:0] fwd_pick(input sb_entry_t ex, input sb_entry_t mem,
                                          input sb_entry_t wb, input logic [4:0] r,
                                          input logic en);
    if (!en)               return {1'b0, FWD_RF};
    if (sb_match(ex, r))   return ex.memread ? {1'b1, FWD_RF} : {1'b0, FWD_EX};
    if (sb_match(mem, r))  return {1'b0, FWD_MEM};
    if (sb_match(wb, r))   return {1'b0, FWD_WB};
    return {1'b0, FWD_RF};
  endfunction

endpackage

// File: rtl/hazard_ctrl_sb_entry.sv
// One registered stage of the shadow scoreboard (EX, MEM or WB),
// cleared to a bubble by the asynchronous active-low reset.
module sb_entry
  import hazard_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  sb_entry_t i_d,
  output sb_entry_t o_q
);

  sb_entry_t r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_q <= SB_BUBBLE;
    else          r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow scoreboard of EX/MEM/WB driving
// operand forwarding, load-use stall, branch flush and drain/halt.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_issue_valid,
  input  logic [4:0] i_issue_rd,
  input  logic       i_issue_regwrite,
  input  logic       i_issue_memread,
  input  logic [4:0] i_rn_id,
  input  logic [4:0] i_rm_id,
  input  logic       i_use_rn,
  input  logic       i_use_rm,
  input  logic       i_branch_taken,
  input  logic       i_halt_req,
  output logic [1:0] o_fwd_a,
  output logic [1:0] o_fwd_b,
  output logic       o_stall,
  output logic       o_flush_ifid,
  output logic       o_halted
);

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t     r_state, w_state_next;
  logic [2:0] r_cnt, w_cnt_next;
  logic       w_stall, w_flush, w_issue_ok, w_load_use;
  logic [2:0] w_pick_a, w_pick_b;
  sb_entry_t  w_issue;
  sb_entry_t  w_sb_d [3];
  sb_entry_t  w_sb_q [3];

  // Index 0 = EX, 1 = MEM, 2 = WB; each stage feeds the next.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sb
      sb_entry u_sb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (w_sb_d[gi]),
        .o_q     (w_sb_q[gi])
      );
      if (gi > 0) begin : g_shift
        assign w_sb_d[gi] = w_sb_q[gi-1];
      end
    end
  endgenerate

  assign w_issue    = '{valid: 1'b1, rd: i_issue_rd, regwrite: i_issue_regwrite,
                        memread: i_issue_memread};
  assign w_issue_ok = i_issue_valid && !w_stall && !w_flush && (r_state == RUN);
  assign w_sb_d[0]  = w_issue_ok ? w_issue : SB_BUBBLE;

  assign w_pick_a   = fwd_pick(w_sb_q[0], w_sb_q[1], w_sb_q[2], i_rn_id, i_use_rn);
  assign w_pick_b   = fwd_pick(w_sb_q[0], w_sb_q[1], w_sb_q[2], i_rm_id, i_use_rm);
  assign w_load_use = w_pick_a[2] | w_pick_b[2];

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_flush      = 1'b0;
    w_stall      = 1'b0;
    case (r_state)
      RUN: begin
        if (i_halt_req) begin
          w_state_next = DRAIN;
          w_stall      = w_load_use;
        end else if (i_branch_taken) begin
          // The branch cycle itself is the first flush cycle.
          w_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_state_next = FLUSH;
            w_cnt_next   = CNT_LOAD;
          end
        end else begin
          w_stall = w_load_use;
        end
      end
      FLUSH: begin
        w_flush = 1'b1;
        if (i_halt_req) begin
          w_state_next = DRAIN;
          w_cnt_next   = 3'd0;
        end else if (i_branch_taken) begin
          w_cnt_next = CNT_LOAD;
        end else begin
          w_cnt_next = (r_cnt == 3'd0) ? 3'd0 : r_cnt - 3'd1;
          if (r_cnt <= 3'd1) w_state_next = RUN;
        end
      end
      DRAIN: begin
        // S_EX refills with a bubble, so empty EX and MEM means the next scoreboard is empty.
        if (!w_sb_q[0].valid && !w_sb_q[1].valid) w_state_next = HALTED;
      end
      HALTED: begin
        w_stall = 1'b1;
        if (!i_halt_req) w_state_next = RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign o_fwd_a      = w_pick_a[1:0];
  assign o_fwd_b      = w_pick_b[1:0];
  assign o_stall      = w_stall;
  assign o_flush_ifid = w_flush;
  assign o_halted     = (r_state == HALTED);

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage CPU. It keeps a shadow scoreboard of the instructions in EX, MEM and WB, and from it produces:
- forwarding selects for the two ID-stage operands;
- load-use stalls;
- branch flushes;
- a drain/halt sequence.

It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WR pipeline registers and drives their enable, flush and bubble controls.

## Interface
- FLUSH_CYCLES, default 1: number of cycles `flush_ifid` stays asserted after a taken branch (1..7).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  the ID-stage instruction is real (not a bubble).
- issue_rd  in  5  destination register of the ID instruction.
- issue_regwrite  in  1  the ID instruction writes the register file.
- issue_memread  in  1  the ID instruction is a load.
- rn_id, rm_id  in  5 each  source registers of the ID instruction.
- use_rn, use_rm  in  1 each  the corresponding source is actually read.
- branch_taken  in  1  taken branch resolved this cycle.
- halt_req  in  1  request to stop issuing and drain the pipeline.
- fwd_a, fwd_b  out  2 each  operand source select: 00 register file, 01 EX result, 10 MEM result, 11 WB data.
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- flush_ifid  out  1  squash the IF/ID contents.
- halted  out  1  pipeline empty and held.

## Operation
- Shadow scoreboard: three entries S_EX, S_MEM, S_WB, each holding {valid, rd, regwrite, memread}.
- Scoreboard shift, every cycle not in reset:
  - S_WB <= S_MEM; S_MEM <= S_EX.
  - S_EX <= the issued instruction only when issue_valid && !stall && !flush_ifid && state==RUN; otherwise S_EX <= invalid (bubble).
- Match on stage X for source register r: X.valid && X.regwrite && X.rd==r && r!=31. X31 (XZR) never matches.
- Forwarding, per operand, applied only if the use_* bit is set: first match wins in the order S_EX (01), S_MEM (10), S_WB (11); otherwise 00.
  - An S_EX match on a load does not forward. It yields 00 and raises a load-use hazard.
- stall = state==RUN && load-use hazard on either used operand.
- States: RUN, FLUSH, DRAIN, HALTED. Reset state is RUN.
  - RUN -> FLUSH on branch_taken. Load the flush counter with FLUSH_CYCLES-1; flush_ifid=1 in that same cycle (combinational from branch_taken).
  - FLUSH: flush_ifid=1 and the counter decrements. Go to RUN when the counter is 0 and branch_taken=0.
  - RUN or FLUSH -> DRAIN on halt_req. halt_req has priority over branch_taken.
  - DRAIN: no issue into S_EX. Go to HALTED when S_EX, S_MEM and S_WB are all invalid.
  - HALTED: halted=1 and stall=1. Go to RUN when halt_req deasserts.
- Simultaneous load-use hazard and branch_taken: the flush wins, stall=0, and the bubble enters S_EX.
- branch_taken while in FLUSH reloads the counter.

## Timing
- Reset values:
  - fwd_a=fwd_b=00, stall=0, flush_ifid=0, halted=0.
  - All scoreboard entries invalid; state RUN; counter 0.
- fwd_*, stall and flush_ifid are combinational from registered state and current inputs, valid in the same cycle.
- halted is a registered state decode.
- Load-use costs exactly 1 stall cycle. In the next cycle the load is in S_MEM and fwd selects 10.
- Total flush length is FLUSH_CYCLES cycles, counting the branch_taken cycle.
- Drain latency is at most 3 cycles after entering DRAIN.
- Reset asserted mid-operation clears everything immediately. No partial state survives deassertion.

## Structure
- Shared package `hazard_pkg`:
  - state enum {RUN, FLUSH, DRAIN, HALTED};
  - fwd select localparams FWD_RF, FWD_EX, FWD_MEM, FWD_WB;
  - XZR=5'd31;
  - scoreboard entry struct.
- One sub-module `sb_entry`: a registered scoreboard stage with async active-low clear, instantiated 3 times.
- The forwarding compare is a function in `hazard_pkg`.

## Test plan
1. Reset low mid-stream with valid entries -> all outputs 0 and halted=0 immediately; after release, fwd_a=00 with matching rn.
2. Issue ADD X3 (regwrite), next cycle rn_id=3 -> fwd_a=01; a cycle later -> 10; a cycle later -> 11; the following cycle -> 00.
3. Issue LDUR X5, next cycle rm_id=5 with use_rm -> stall=1, fwd_b=00 for 1 cycle; next cycle stall=0, fwd_b=10.
4. Issue writes to X31, then read rn=31 -> fwd_a=00 and stall=0 throughout.
5. FLUSH_CYCLES=2, branch_taken pulse -> flush_ifid high 2 cycles and no issue into S_EX; a simultaneous load-use hazard gives stall=0.
6. halt_req with 3 valid stages -> halted rises after the scoreboard empties (≤3 cycles) with stall=1; deassert halt_req -> RUN, stall=0.
